// File: rtl/fir_seq_pkg.sv
// Shared types and helpers for the serial FIR control sequencer.
package fir_seq_pkg;

    // Sequencer states: zero the delay line, wait for a sample, walk the taps,
    // latch the sum, wait out the memory latency, then hand the result off.
    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DUMP  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_OUT   = 3'd5
    } fir_seq_state_e;

    // Wide enough for any practical tap count; callers truncate to their own width.
    localparam int unsigned TAP_ADDR_W = 16;

    // Delay-line slot holding the sample k taps older than the newest one at wp.
    // The mask is N-1, which gives the modulo because N is a power of two.
    function automatic logic [TAP_ADDR_W-1:0] tap_addr(
        input logic [TAP_ADDR_W-1:0] wp,
        input logic [TAP_ADDR_W-1:0] k,
        input logic [TAP_ADDR_W-1:0] mask
    );
        return (wp - k) & mask;
    endfunction

endpackage

// File: rtl/fir_seq_align.sv
// Delays the MAC issue flags {enable, first, dump} so they line up with the
// data coming back from the delay-line and coefficient memories.
module fir_seq_align
    import fir_seq_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] issue_i,
    output logic [2:0] issue_o
);

    if (DEPTH == 0) begin : g_pass
        // Combinational memories: the flags already line up with the data.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign issue_o        = issue_i;
    end else begin : g_pipe
        logic [2:0] pipe_q [DEPTH];

        // Shift the flags one stage per cycle; reset kills any in-flight issue.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                pipe_q[0] <= issue_i;
                for (int i = 1; i < DEPTH; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign issue_o = pipe_q[DEPTH-1];
    end

endmodule

// File: rtl/fir_sequencer.sv
// Control sequencer for the time-multiplexed serial FIR: accepts a sample,
// writes it into the circular delay line, walks every tap once, strobes the
// MAC to latch the sum and offers the result through a valid/ready handshake.
module fir_sequencer
    import fir_seq_pkg::*;
#(
    parameter int NUMBER_OF_TAPS = 64,
    parameter int READ_LATENCY   = 1,
    parameter int ADDR_BITS      = $clog2(NUMBER_OF_TAPS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 delay_wr_en,
    output logic                 delay_wr_zero,
    output logic [ADDR_BITS-1:0] delay_wr_addr,
    output logic [ADDR_BITS-1:0] delay_rd_addr,
    output logic [ADDR_BITS-1:0] coeff_addr,
    output logic                 mac_clk_enable,
    output logic                 mac_phase_min,
    output logic                 busy
);

    if (READ_LATENCY < 0 || READ_LATENCY > 1) begin : g_bad_latency
        $error("fir_sequencer: READ_LATENCY must be 0 or 1");
    end
    if (NUMBER_OF_TAPS < 2 || (NUMBER_OF_TAPS & (NUMBER_OF_TAPS - 1)) != 0) begin : g_bad_taps
        $error("fir_sequencer: NUMBER_OF_TAPS must be a power of two >= 2");
    end

    localparam logic [ADDR_BITS-1:0]  K_LAST    = ADDR_BITS'(NUMBER_OF_TAPS - 1);
    localparam logic [TAP_ADDR_W-1:0] ADDR_MASK = TAP_ADDR_W'(NUMBER_OF_TAPS - 1);

    fir_seq_state_e        state_q, state_d;
    logic [ADDR_BITS-1:0]  wp_q, wp_d;
    logic [ADDR_BITS-1:0]  k_q, k_d;
    logic                  clear_pend_q, clear_pend_d;

    // Issue flags as generated in the address cycle, before alignment.
    logic                  iss_enable;
    logic                  iss_first;
    logic                  iss_dump;
    logic [2:0]            iss_aligned;

    // State, write pointer, tap counter and deferred-clear flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_CLEAR;
            wp_q         <= '0;
            k_q          <= '0;
            clear_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wp_q         <= wp_d;
            k_q          <= k_d;
            clear_pend_q <= clear_pend_d;
        end
    end

    // Next-state logic and all memory/MAC control outputs for the current state.
    always_comb begin
        state_d       = state_q;
        wp_d          = wp_q;
        k_d           = k_q;
        clear_pend_d  = clear_pend_q;

        in_ready      = 1'b0;
        out_valid     = 1'b0;
        busy          = 1'b1;
        delay_wr_en   = 1'b0;
        delay_wr_zero = 1'b0;
        delay_wr_addr = '0;
        delay_rd_addr = '0;
        coeff_addr    = '0;
        iss_enable    = 1'b0;
        iss_first     = 1'b0;
        iss_dump      = 1'b0;

        // A clear arriving mid-round is remembered so the round can finish
        // and deliver its result before the delay line is wiped.
        if (clear && state_q != ST_IDLE && state_q != ST_CLEAR) begin
            clear_pend_d = 1'b1;
        end

        unique case (state_q)
            ST_CLEAR: begin
                delay_wr_en   = 1'b1;
                delay_wr_zero = 1'b1;
                delay_wr_addr = k_q;
                if (k_q == K_LAST) begin
                    state_d = ST_IDLE;
                    wp_d    = '0;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end

            ST_IDLE: begin
                busy     = 1'b0;
                in_ready = !clear && !clear_pend_q;
                if (clear || clear_pend_q) begin
                    state_d      = ST_CLEAR;
                    k_d          = '0;
                    clear_pend_d = 1'b0;
                end else if (in_valid) begin
                    // New sample lands at wp before the tap-0 read next cycle.
                    delay_wr_en   = 1'b1;
                    delay_wr_addr = wp_q;
                    state_d       = ST_RUN;
                    k_d           = '0;
                end
            end

            ST_RUN: begin
                delay_rd_addr = ADDR_BITS'(tap_addr(TAP_ADDR_W'(wp_q), TAP_ADDR_W'(k_q), ADDR_MASK));
                coeff_addr    = k_q;
                iss_enable    = 1'b1;
                iss_first     = (k_q == '0);
                if (k_q == K_LAST) begin
                    state_d = ST_DUMP;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end

            ST_DUMP: begin
                // phase_min without enable latches the final sum untouched.
                iss_dump = 1'b1;
                state_d  = (READ_LATENCY == 0) ? ST_OUT : ST_DRAIN;
            end

            ST_DRAIN: begin
                state_d = ST_OUT;
            end

            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    wp_d    = wp_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_CLEAR;
                k_d     = '0;
            end
        endcase
    end

    fir_seq_align #(
        .DEPTH   (READ_LATENCY)
    ) u_align (
        .clk     (clk),
        .rst     (rst),
        .issue_i ({iss_enable, iss_first, iss_dump}),
        .issue_o (iss_aligned)
    );

    assign mac_clk_enable = iss_aligned[2];
    assign mac_phase_min  = iss_aligned[1] | iss_aligned[0];

endmodule

// File: tb/tb_fir_sequencer.sv
// Scoreboard bench for fir_sequencer with N = 4 taps and read latency 1.
`timescale 1ns/1ps
module tb_fir_sequencer;

    localparam int N  = 4;
    localparam int L  = 1;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic          in_ready;
    logic          out_valid;
    logic          delay_wr_en;
    logic          delay_wr_zero;
    logic [AW-1:0] delay_wr_addr;
    logic [AW-1:0] delay_rd_addr;
    logic [AW-1:0] coeff_addr;
    logic          mac_clk_enable;
    logic          mac_phase_min;
    logic          busy;

    fir_sequencer #(
        .NUMBER_OF_TAPS (N),
        .READ_LATENCY   (L)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .clear          (clear),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .delay_wr_en    (delay_wr_en),
        .delay_wr_zero  (delay_wr_zero),
        .delay_wr_addr  (delay_wr_addr),
        .delay_rd_addr  (delay_rd_addr),
        .coeff_addr     (coeff_addr),
        .mac_clk_enable (mac_clk_enable),
        .mac_phase_min  (mac_phase_min),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Expected-response queues: writes {zero, addr}, MAC issues {en, pm, rd, coeff},
    // and the cycle on which out_valid must rise.
    logic [2:0]    wq[$];
    logic [5:0]    iq[$];
    int            oq[$];
    logic [AW-1:0] acc_q[$];
    logic [AW-1:0] wp_m = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_clear();
        for (int k = 0; k < N; k++) wq.push_back({1'b1, AW'(k)});
        wp_m = '0;
    endtask

    task automatic push_round(input int c);
        wq.push_back({1'b0, wp_m});
        for (int k = 0; k < N; k++) begin
            logic [AW-1:0] kk;
            kk = AW'(k);
            iq.push_back({1'b1, (k == 0), AW'(wp_m - kk), kk});
        end
        iq.push_back({1'b0, 1'b1, 2'b00, 2'b00});
        oq.push_back(c + N + 2 + L);
        wp_m = wp_m + 1'b1;
    endtask

    // Offer n samples back to back; returns the cycle of the last acceptance.
    task automatic send(input int n, output int tacc);
        tacc = -1;
        @(posedge clk); #1;
        in_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            int w;
            w = 0;
            @(negedge clk);
            while (!in_ready && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (!in_ready) begin
                chk("accept_timeout", 0, 1);
            end else begin
                tacc = cyc;
                acc_q.push_back(delay_wr_addr);
                push_round(cyc);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic goto_neg(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"},      busy, 1);
        chk({tag, "_wr_en"},     delay_wr_en, 1);
        chk({tag, "_wr_zero"},   delay_wr_zero, 1);
        chk({tag, "_wr_addr"},   delay_wr_addr, 0);
        chk({tag, "_mac_en"},    mac_clk_enable, 0);
        chk({tag, "_mac_pm"},    mac_phase_min, 0);
    endtask

    // Monitor: pops the matching expectation whenever the DUT shows activity.
    logic [AW-1:0] prev_rd = '0;
    logic [AW-1:0] prev_co = '0;
    logic          prev_ov = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_ov <= 1'b0;
            prev_rd <= '0;
            prev_co <= '0;
        end else begin
            if (delay_wr_en) begin
                if (wq.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    chk("wr_zero", delay_wr_zero, wq[0][2]);
                    chk("wr_addr", delay_wr_addr, wq[0][1:0]);
                    void'(wq.pop_front());
                end
            end
            if (mac_clk_enable || mac_phase_min) begin
                if (iq.size() == 0) chk("mac_unexpected", 1, 0);
                else begin
                    chk("mac_en",     mac_clk_enable, iq[0][5]);
                    chk("mac_pm",     mac_phase_min,  iq[0][4]);
                    chk("rd_addr",    prev_rd,        iq[0][3:2]);
                    chk("coeff_addr", prev_co,        iq[0][1:0]);
                    void'(iq.pop_front());
                end
            end
            if (out_valid && !prev_ov) begin
                if (oq.size() == 0) chk("out_unexpected", 1, 0);
                else begin
                    chk("out_rise_cycle", cyc, oq[0]);
                    void'(oq.pop_front());
                end
            end
            prev_ov <= out_valid;
            prev_rd <= delay_rd_addr;
            prev_co <= coeff_addr;
        end
    end

    initial begin
        int t;
        int c;
        logic [AW-1:0] b2b_wr [5];
        b2b_wr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        // Reset values, then exactly N zero-writes before the first in_ready.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        push_clear();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i <= N; i++) begin
            @(negedge clk);
            chk("in_ready_after_reset", in_ready, (i == N));
        end

        // Five back-to-back rounds: write pointer wraps 0,1,2,3,0.
        acc_q.delete();
        send(5, t);
        for (int i = 0; i < 5; i++) begin
            if (acc_q.size() == 0) chk("b2b_count", 0, 1);
            else chk("b2b_wr_addr", acc_q.pop_front(), b2b_wr[i]);
        end
        goto_neg(t + N + 4);

        // Consumer stalls for 10 cycles: result held, no new sample, wp waits.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(1, t);
        goto_neg(t + N + 2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready",  in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("hold_accept_valid", out_valid, 1);
        @(negedge clk);
        chk("hold_after_valid", out_valid, 0);
        chk("hold_after_busy",  busy, 0);
        send(1, t);
        goto_neg(t + N + 4);

        // Clear during a round: result first, then an N-cycle clear, wp back to 0.
        send(1, t);
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        push_clear();
        goto_neg(t + N + 3);
        chk("clr_round_out_valid", out_valid, 1);
        goto_neg(t + N + 4);
        chk("clr_idle_busy",     busy, 0);
        chk("clr_idle_in_ready", in_ready, 0);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            chk("clr_busy", busy, 1);
        end
        @(negedge clk);
        chk("clr_done_in_ready", in_ready, 1);
        send(1, t);
        goto_neg(t + N + 4);

        // clear and in_valid together in IDLE: clear wins, sample taken afterwards.
        @(posedge clk); #1;
        clear    = 1'b1;
        in_valid = 1'b1;
        c        = cyc;
        @(negedge clk);
        chk("clr_vs_valid_in_ready", in_ready, 0);
        chk("clr_vs_valid_wr_en",    delay_wr_en, 0);
        @(posedge clk); #1;
        clear = 1'b0;
        push_clear();
        send(1, t);
        chk("clr_vs_valid_accept_cycle", t, c + N + 1);
        goto_neg(t + N + 4);

        // Reset mid-round at T+3: outputs snap to reset values, clear restarts.
        send(1, t);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        wq.delete();
        iq.delete();
        oq.delete();
        push_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i <= N; i++) begin
            @(negedge clk);
            chk("in_ready_after_abort", in_ready, (i == N));
        end
        send(1, t);
        goto_neg(t + N + 4);

        chk("wq_empty", wq.size(), 0);
        chk("iq_empty", iq.size(), 0);
        chk("oq_empty", oq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fir_sequencer.md
# fir_sequencer

Control sequencer for the time-multiplexed serial FIR datapath. It accepts one input sample per round through a valid/ready handshake and writes it into a circular delay-line memory. It then walks all taps one per cycle, driving the delay-line read address, the coefficient address and the MAC's `clk_enable`/`phase_min` controls. Finally it latches the saturated result and presents it through a valid/ready output handshake. It sits between the sample source, the delay/coefficient memories and the serial MAC compute block.

## Interface
Parameters:
- `NUMBER_OF_TAPS`, 64: taps per round; power of two, ≥ 2.
- `READ_LATENCY`, 1: cycles from address to data at the delay/coeff memories; 0 or 1 only.
- `ADDR_BITS`, `$clog2(NUMBER_OF_TAPS)`: width of all address outputs.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `clear` in 1: synchronous request to zero the delay line.
- `in_valid` in 1: input sample offered.
- `in_ready` out 1: sample accepted when `in_valid && in_ready`.
- `out_valid` out 1: MAC `filter_out` holds a completed result.
- `out_ready` in 1: consumer accepts the result.
- `delay_wr_en` out 1: delay-line write strobe.
- `delay_wr_zero` out 1: write zero instead of the input sample.
- `delay_wr_addr` out ADDR_BITS: delay-line write address.
- `delay_rd_addr` out ADDR_BITS: delay-line read address.
- `coeff_addr` out ADDR_BITS: coefficient index.
- `mac_clk_enable` out 1: MAC accumulate enable.
- `mac_phase_min` out 1: MAC phase-start / result-latch strobe.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: CLEAR, IDLE, RUN, DUMP, DRAIN, OUT. Registers: `wp` (write pointer), `k` (tap/clear counter), `clear_pend`.
- CLEAR:
  - Asserts `delay_wr_en` and `delay_wr_zero`, with `delay_wr_addr = k`, for k = 0..N-1.
  - Then goes to IDLE with `wp = 0`.
  - Reset enters CLEAR with k = 0.
- IDLE:
  - `in_ready = !clear && !clear_pend`.
  - `clear` or `clear_pend` → CLEAR; clear has priority over a simultaneous `in_valid`.
  - On accept: `delay_wr_en = 1`, `delay_wr_zero = 0`, `delay_wr_addr = wp`; then RUN with k = 0.
- RUN (N cycles):
  - Issues `delay_rd_addr = (wp − k) mod N` and `coeff_addr = k`, with issue-enable = 1 and issue-first = (k == 0).
  - After k = N−1, goes to DUMP.
- DUMP (1 cycle): issues issue-dump (phase_min = 1, enable = 0), which latches the final sum without disturbing the accumulator.
  - READ_LATENCY = 0 → OUT.
  - Otherwise → DRAIN.
- DRAIN (READ_LATENCY cycles): no issue; then OUT.
- OUT:
  - `out_valid = 1`, held until `out_ready`.
  - On accept: `wp <= wp + 1` (wraps N−1 → 0), then IDLE.
- Alignment pipeline: the issue flags are delayed by READ_LATENCY cycles.
  - `mac_clk_enable = d_enable`.
  - `mac_phase_min = d_first | d_dump`.
- `clear` asserted outside IDLE/CLEAR sets `clear_pend`. It is honoured on the next entry to IDLE, so the current round completes and its result is delivered first.
- `clear` during CLEAR is ignored.
- Outputs not named for a state are 0. Addresses are don't-care when their strobes are low; they are driven to 0 there.

## Timing
- Reset values (while `rst` is high), reflecting CLEAR with k = 0:
  - state = CLEAR, `wp = 0`, `clear_pend = 0`, alignment pipeline zeroed.
  - `in_ready = 0`, `out_valid = 0`, `busy = 1`.
  - `delay_wr_en = 1`, `delay_wr_zero = 1`, `delay_wr_addr = 0`.
  - `mac_clk_enable = 0`, `mac_phase_min = 0`.
- Memories are clocked, so a write asserted during reset is harmless.
- First `in_ready` is N cycles after reset release.
- Sample accepted at cycle T (L = READ_LATENCY):
  - Write occurs at T.
  - RUN spans T+1..T+N.
  - MAC enables are high at T+1+L..T+N+L; `mac_phase_min` is high at T+1+L.
  - Dump strobe at T+N+1+L.
  - `out_valid` rises at T+N+2+L.
- Round period is N+3+L cycles when `out_ready` is held high.
- Read-after-write is safe: the write at T lands before the tap-0 read at T+1.
- Reset asserted mid-round aborts the round immediately. `out_valid` drops asynchronously and the result is lost.

## Structure
- `fir_seq_pkg`: state enum `fir_seq_state_e`; the helper function `tap_addr(wp, k)`.
- Sub-module `fir_seq_align`: a READ_LATENCY-deep shift register for {enable, first, dump}; pass-through when the depth is 0.

## Test plan
- Reset release with N = 4: exactly 4 zero-writes to addresses 0,1,2,3, then `in_ready = 1` at cycle 4.
- N = 4, L = 1, one sample accepted at T with `wp = 0`:
  - `delay_rd_addr` sequence 0,3,2,1 and `coeff_addr` 0,1,2,3 at T+1..T+4.
  - `mac_phase_min` high at T+2 and T+6.
  - `out_valid` rises at T+7.
- `out_ready` held low for 10 cycles: `out_valid` stays high, no new `in_ready`, and `wp` advances only on accept.
- Five back-to-back samples with N = 4: write addresses 0,1,2,3,0 (wrap), each round's reads start at that round's `wp`.
- `clear` pulsed at T+2 of a round: the round completes and the result is delivered; after acceptance, CLEAR runs for 4 cycles, then `wp = 0`.
- `clear` and `in_valid` high together in IDLE: `in_ready = 0`, CLEAR is entered, and the sample is taken only afterwards. A separate case asserts reset at T+3: all outputs reach their reset values, and CLEAR restarts.
